// File: rtl/ariane_reset_sequencer_pkg.sv
// Shared types for the per-hart reset sequencer: wake policy and hart FSM states.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      WAKE_CNT     = 2'd0,
      WAKE_EVT     = 2'd1,
      WAKE_CNT_EVT = 2'd2
   } wake_mode_e;

   typedef enum logic [2:0] {
      COUNT     = 3'd0,
      WAIT_WAKE = 3'd1,
      STAGGER   = 3'd2,
      RUN       = 3'd3,
      SWRST     = 3'd4
   } hart_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ariane_reset_sequencer_if.sv
// Tile-side bundle of per-hart wake/re-reset requests, interrupt lines and released core resets.
interface ariane_reset_sequencer_if #(
   parameter int NrHarts = 1,
   parameter int NrIrq   = 2
);
   logic [NrHarts-1:0]       wake_val_i;
   logic [NrHarts-1:0]       sw_rst_req_i;
   logic [NrHarts*NrIrq-1:0] irq_i;
   logic [NrHarts-1:0]       ipi_i;
   logic [NrHarts-1:0]       time_irq_i;
   logic [NrHarts-1:0]       debug_req_i;
   logic [NrHarts-1:0]       hart_rst_no;
   logic [NrHarts*NrIrq-1:0] irq_o;
   logic [NrHarts-1:0]       ipi_o;
   logic [NrHarts-1:0]       time_irq_o;
   logic [NrHarts-1:0]       debug_req_o;
   logic                     all_run_o;

   modport master (
      output wake_val_i, sw_rst_req_i, irq_i, ipi_i, time_irq_i, debug_req_i,
      input  hart_rst_no, irq_o, ipi_o, time_irq_o, debug_req_o, all_run_o
   );

   modport slave (
      input  wake_val_i, sw_rst_req_i, irq_i, ipi_i, time_irq_i, debug_req_i,
      output hart_rst_no, irq_o, ipi_o, time_irq_o, debug_req_o, all_run_o
   );
endinterface

// File: rtl/ariane_reset_sequencer_hart_reset_fsm.sv
// One hart's release sequencing: wait policy, sticky wake latch, stagger/re-reset
// down-counter and the release chain that drives the active-low core reset.
module hart_reset_fsm
   import reset_seq_pkg::*;
#(
   parameter int         NrHarts       = 1,
   parameter int         HartIdx       = 0,
   parameter wake_mode_e WakeMode      = WAKE_CNT,
   parameter int         StaggerCycles = 0,
   parameter int         SwRstCycles   = 16,
   parameter int         SyncStages    = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_cnt_done,
   input  logic i_wake,
   input  logic i_sw_rst_req,
   output logic o_rst_n
);
   localparam int          StgLoad    = HartIdx * StaggerCycles;
   localparam int          MaxLoad    = max_int((NrHarts - 1) * StaggerCycles, SwRstCycles);
   localparam int          CntW       = $clog2(MaxLoad + 1);
   localparam hart_state_e ResetState = (WakeMode == WAKE_EVT) ? WAIT_WAKE : COUNT;
   // Hart 0 and unstaggered tiles go straight to RUN.
   localparam hart_state_e RelState   = (StgLoad == 0) ? RUN : STAGGER;

   hart_state_e           r_state;
   hart_state_e           w_state_nxt;
   logic [CntW-1:0]       r_cnt;
   logic [CntW-1:0]       w_cnt_nxt;
   logic                  r_wake;
   logic                  w_wake;
   logic                  w_pre_run;
   logic [SyncStages-1:0] r_chain;

   // A pulse on the deciding edge counts as well as one latched earlier.
   assign w_wake    = r_wake | i_wake;
   assign w_pre_run = (r_state == COUNT) | (r_state == WAIT_WAKE) | (r_state == STAGGER);

   // Next state and down-counter load/decrement
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         COUNT: begin
            if (!i_cnt_done) begin
               w_state_nxt = COUNT;
            end else if ((WakeMode == WAKE_CNT_EVT) && !w_wake) begin
               w_state_nxt = WAIT_WAKE;
            end else begin
               w_state_nxt = RelState;
               w_cnt_nxt   = CntW'(StgLoad);
            end
         end
         WAIT_WAKE: begin
            if (w_wake) begin
               w_state_nxt = RelState;
               w_cnt_nxt   = CntW'(StgLoad);
            end else begin
               w_state_nxt = WAIT_WAKE;
            end
         end
         STAGGER: begin
            if (r_cnt <= CntW'(1)) begin
               w_state_nxt = RUN;
            end else begin
               w_cnt_nxt = r_cnt - CntW'(1);
            end
         end
         RUN: begin
            if (i_sw_rst_req) begin
               w_state_nxt = SWRST;
               w_cnt_nxt   = CntW'(SwRstCycles);
            end else begin
               w_state_nxt = RUN;
            end
         end
         SWRST: begin
            if (r_cnt <= CntW'(1)) begin
               w_state_nxt = RUN;
            end else begin
               w_cnt_nxt = r_cnt - CntW'(1);
            end
         end
         default: begin
            w_state_nxt = ResetState;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State register, down-counter and sticky wake latch
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ResetState;
         r_cnt   <= '0;
         r_wake  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wake  <= r_wake | (i_wake & w_pre_run);
      end
   end

   // Release chain: fills with RUN, flushed on the edge that leaves RUN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_chain <= '0;
      end else if ((r_state == RUN) && (w_state_nxt != RUN)) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SyncStages-2:0], (r_state == RUN)};
      end
   end

   assign o_rst_n = r_chain[SyncStages-1];

endmodule

// File: rtl/ariane_reset_sequencer.sv
// Per-hart reset release and interrupt conditioning for multi-hart CVA6 tiles.
// Holds the shared SRAM-init counter and interrupt synchronisers; one hart_reset_fsm per hart.
module ariane_reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int         NrHarts       = 1,
   parameter int         NrIrq         = 2,
   parameter int         WaitCycles    = 32768,
   parameter wake_mode_e WakeMode      = WAKE_CNT,
   parameter int         StaggerCycles = 0,
   parameter int         SwRstCycles   = 16,
   parameter int         SyncStages    = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   ariane_reset_sequencer_if.slave bus
);
   localparam int CntW   = $clog2(WaitCycles + 1);
   localparam int NrBits = NrHarts * (NrIrq + 3);

   if (NrHarts < 1) begin : g_bad_harts
      $error("NrHarts must be at least 1");
   end
   if (WaitCycles < 1) begin : g_bad_wait
      $error("WaitCycles must be at least 1");
   end
   if (SwRstCycles < 1) begin : g_bad_swrst
      $error("SwRstCycles must be at least 1");
   end
   if (SyncStages < 2) begin : g_bad_sync
      $error("SyncStages must be at least 2");
   end

   logic [CntW-1:0]                   r_cnt;
   logic                              w_cnt_done;
   logic [NrHarts-1:0]                w_rst_n;
   logic [NrBits-1:0]                 w_async;
   logic [NrBits-1:0]                 w_gate;
   logic [NrBits-1:0]                 w_synced;
   logic [SyncStages-1:0][NrBits-1:0] r_sync;

   // Shared SRAM-init wait counter, saturating at WaitCycles
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (r_cnt != CntW'(WaitCycles)) begin
         r_cnt <= r_cnt + CntW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign w_cnt_done = (r_cnt == CntW'(WaitCycles));

   for (genvar h = 0; h < NrHarts; h++) begin : g_hart
      hart_reset_fsm #(
         .NrHarts      (NrHarts),
         .HartIdx      (h),
         .WakeMode     (WakeMode),
         .StaggerCycles(StaggerCycles),
         .SwRstCycles  (SwRstCycles),
         .SyncStages   (SyncStages)
      ) u_fsm (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .i_cnt_done  (w_cnt_done),
         .i_wake      (bus.wake_val_i[h]),
         .i_sw_rst_req(bus.sw_rst_req_i[h]),
         .o_rst_n     (w_rst_n[h])
      );
   end

   // Bit layout: {debug, time, ipi, irq}, each hart-major.
   assign w_async = {bus.debug_req_i, bus.time_irq_i, bus.ipi_i, bus.irq_i};

   // Synchroniser stages for every async line; stage 0 is the capture flop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SyncStages-2:0], w_async};
      end
   end

   // Per-bit gate: each line follows its own hart's released reset
   always_comb begin
      w_gate = '0;
      for (int h = 0; h < NrHarts; h++) begin
         w_gate[h*NrIrq +: NrIrq] = {NrIrq{w_rst_n[h]}};
      end
      w_gate[NrHarts*NrIrq +: 3*NrHarts] = {3{w_rst_n}};
   end

   assign w_synced        = r_sync[SyncStages-1] & w_gate;
   assign bus.irq_o       = w_synced[0 +: NrHarts*NrIrq];
   assign bus.ipi_o       = w_synced[NrHarts*NrIrq +: NrHarts];
   assign bus.time_irq_o  = w_synced[NrHarts*NrIrq + NrHarts +: NrHarts];
   assign bus.debug_req_o = w_synced[NrHarts*NrIrq + 2*NrHarts +: NrHarts];
   assign bus.hart_rst_no = w_rst_n;
   assign bus.all_run_o   = &w_rst_n;

endmodule
